data_mem_stage: RTL and testbench
=================================

Name: data_mem_stage

Overview:
- Memory stage directly downstream of the ALU.
- Consumes the ALU result as a byte address, plus store data from the register file, and performs one word load or store against a local word-addressed RAM.
- Access latency is configurable. A busy/valid handshake lets the core stall the pipeline while an access is in flight.
- Misaligned word accesses are flagged and suppressed instead of being performed.

Parameters:
- DEPTH, 64, number of 32-bit words in the RAM. Must be a power of 2, at least 4.
- LATENCY, 2, number of wait cycles before the access commits. Range 0..15.

Ports:
- i_clk  input  1  clock. All state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req  input  1  access request. Sampled only in IDLE.
- i_we  input  1  1 = store (sw), 0 = load (lw). Sampled with i_req.
- i_addr  input  32  byte address, the ALU result. Sampled with i_req.
- i_wdata  input  32  store data. Sampled with i_req.
- o_rdata  output  32  load data. Holds its value until the next load completes.
- o_valid  output  1  one-cycle pulse: the access has completed.
- o_busy  output  1  high while an accepted access is in flight. The core stalls while it is high.
- o_misaligned  output  1  high together with o_valid when the accepted address had a nonzero addr[1:0].

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, wait counter = 0.
  - o_rdata = 0, o_valid = 0, o_busy = 0, o_misaligned = 0.
  - Captured addr, we and wdata cleared.
  - RAM contents are not reset.
- States: IDLE, WAIT, DONE.
  - o_busy = 1 in WAIT and DONE.
  - o_valid = 1 only in DONE.
- Acceptance: if i_req = 1 in IDLE at edge k, the block captures i_we, i_addr and i_wdata.
  - addr[1:0] != 0: go to DONE with misaligned flag set. No RAM read or write. o_rdata unchanged. o_valid and o_misaligned are both high in the cycle after edge k.
  - Aligned: go to WAIT with cnt = LATENCY.
- WAIT:
  - cnt != 0: cnt decrements by 1 per cycle.
  - cnt == 0: the access commits at that edge, then the state moves to DONE.
  - Store commit: RAM[idx] <= wdata.
  - Load commit: o_rdata <= RAM[idx].
  - idx = addr[log2(DEPTH)+1 : 2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Timing: the commit edge is k+LATENCY+1. o_valid is high for exactly one cycle after it. DONE always returns to IDLE.
- Throughput: the next request can be accepted at edge k+LATENCY+3 at the earliest. Aligned accesses therefore occupy LATENCY+3 cycles per access (k through k+LATENCY+2). Misaligned accesses occupy 2 cycles.
- i_req is ignored in WAIT and DONE. There is no queue; the requester must hold i_req or re-issue it.
- Captured fields are frozen from acceptance to completion. Changes on i_addr, i_wdata or i_we after edge k have no effect.
- Store completion leaves o_rdata unchanged. o_misaligned is 0 for aligned completions.
- Read-after-write: a load accepted after a store's DONE cycle returns the stored data.
- Reset during WAIT or DONE: returns to IDLE immediately with all outputs 0. A store that has not yet committed is abandoned and the RAM is untouched. A store that committed before reset persists.
- i_req asserted in the same cycle as the reset release: not accepted until the first edge with i_rst = 0.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 0x0000_0010 with LATENCY=2, then load 0x10. Required:
  - Store: o_busy high for 4 cycles after acceptance; o_valid pulses once, 3 cycles after the acceptance edge.
  - Load: o_rdata = 0xDEADBEEF together with o_valid; o_misaligned = 0.
- Load from addr 0x0000_0012. Required: o_valid and o_misaligned both high in the cycle after acceptance; o_rdata keeps its previous value; a subsequent load of 0x10 still returns 0xDEADBEEF.
- Wrap-around with DEPTH=64: store 0x12345678 to 0x0000_0104, then load 0x0000_0004. Required: 0x12345678.
- Store 0x1 to 0x20 with i_req held high continuously, while i_addr and i_wdata change every cycle during WAIT. Required:
  - Only the first request is accepted; the second is accepted one cycle after DONE.
  - RAM[8] = 0x1, unaffected by the mid-flight input changes.
- Store 0xAAAA_AAAA to 0x30, and assert i_rst for one cycle during WAIT (cnt = 1). Required:
  - All outputs 0 immediately; state returns to IDLE.
  - Preload RAM[12] = 0x5555_5555 beforehand; a later load of 0x30 returns 0x5555_5555.
- LATENCY=0, back-to-back store and load to 0x40, both with i_req held high. Required:
  - Store o_valid one cycle after acceptance.
  - Load accepted at the earliest legal edge, 3 cycles after the store's acceptance.
  - Load o_valid one cycle after its acceptance, with o_rdata equal to the stored data.

Source files
------------

// File: rtl/data_mem_stage.sv
// Memory stage behind the ALU: one word load or store per request against a local RAM.
// Stores and loads commit LATENCY+1 edges after acceptance. Misaligned addresses are flagged and dropped.
module data_mem_stage #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_misaligned
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               mis_q, mis_d;
    logic               mem_we_s;
    logic               unused_addr_s;

    logic [31:0]        mem [0:DEPTH-1];

    // Word index within the RAM; upper byte-address bits wrap.
    function automatic logic [IDX_W-1:0] word_idx(input logic [IDX_W+1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

    assign unused_addr_s = ^i_addr[31:IDX_W+2];

    // Next-state, capture and output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    addr_d  = i_addr[IDX_W+1:0];
                    we_d    = i_we;
                    wdata_d = i_wdata;
                    if (is_misaligned(i_addr[1:0])) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                    // Commit edge: the store write and the load capture share it.
                    if (we_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = mem[word_idx(addr_q)];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        mis_d   = (state_d == ST_DONE) && is_misaligned(addr_d[1:0]);
    end

    // Control state, captured request and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            mis_q   <= mis_d;
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            mem[word_idx(addr_q)] <= wdata_q;
        end
    end

    assign o_rdata      = rdata_q;
    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: vector table plus scoreboard, hand sequences for held request,
// reset mid-access and zero-latency back-to-back traffic.
`timescale 1ns/1ps
module tb_data_mem_stage;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        valid, busy, mis;
    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        valid0, busy0, mis0;

    always #5 clk = ~clk;

    data_mem_stage #(.DEPTH(64), .LATENCY(LAT)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_rdata(rdata), .o_valid(valid), .o_busy(busy), .o_misaligned(mis)
    );

    data_mem_stage #(.DEPTH(64), .LATENCY(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we0), .i_addr(addr0), .i_wdata(wdata0),
        .o_rdata(rdata0), .o_valid(valid0), .o_busy(busy0), .o_misaligned(mis0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    vec_t  vecs [13];
    exp_t  sb_q [$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion of the LATENCY=2 instance pops one expectation.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_valid: got valid with rdata 0x%08h, expected no completion", rdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_rdata", rdata, mon_e.rdata);
                check("sb_misaligned", {31'd0, mis}, {31'd0, mon_e.mis});
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input logic m);
        exp_t e;
        e.rdata = r;
        e.mis   = m;
        sb_q.push_back(e);
    endtask

    // Issue one access at a negedge, then time its busy/valid behaviour.
    task automatic do_access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                             input logic [31:0] e_rdata, input logic e_mis, input string tag);
        int  busy_cnt = 0;
        int  valid_cnt = 0;
        int  valid_j = -1;
        bit  done = 1'b0;
        int  exp_valid_j;
        int  exp_busy;
        push_exp(e_rdata, e_mis);
        req = 1'b1; we = a_we; addr = a_addr; wdata = a_wdata;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~a_we; addr = $urandom; wdata = $urandom;
        for (int j = 0; j < 40 && !done; j++) begin
            @(negedge clk);
            if (valid) begin
                valid_cnt++;
                valid_j = j;
            end
            if (busy) busy_cnt++;
            else done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still high after 40 cycles, expected idle", tag);
        end
        exp_valid_j = e_mis ? 0 : LAT + 1;
        exp_busy    = e_mis ? 1 : LAT + 2;
        check($sformatf("%s_valid_cycle", tag), 32'(valid_j), 32'(exp_valid_j));
        check($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(exp_busy));
        check($sformatf("%s_valid_pulses", tag), 32'(valid_cnt), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int j = 0; j < 40 && !done; j++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still high after 40 cycles, expected idle", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0104, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0030, 32'h5555_5555, 32'h1234_5678, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0012, 32'h0000_0099, 32'hCAFE_F00D, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0030, 32'h0000_0000, 32'h5555_5555, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_misaligned", {31'd0, mis}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_mis,
                      $sformatf("vec%0d", i));
        end

        // Held request: inputs churn while the first store is in flight.
        push_exp(32'h5555_5555, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_0001;
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("hold_busy_j%0d", j), {31'd0, busy}, 32'd1);
            addr  = 32'h0000_0080 + 32'(4 * j);
            wdata = $urandom;
        end
        @(negedge clk);
        check("hold_idle_before_second", {31'd0, busy}, 32'd0);
        push_exp(32'h0000_0001, 1'b0);
        we = 1'b0; addr = 32'h0000_0020;
        @(posedge clk);
        @(negedge clk);
        check("hold_second_accepted", {31'd0, busy}, 32'd1);
        req = 1'b0;
        wait_idle("hold");
        check("hold_ram8", rdata, 32'h0000_0001);

        // Reset while the store waits with one cycle left.
        req = 1'b1; we = 1'b1; addr = 32'h0000_0030; wdata = 32'hAAAA_AAAA;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_valid", {31'd0, valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_misaligned", {31'd0, mis}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_access(1'b0, 32'h0000_0030, 32'd0, 32'h5555_5555, 1'b0, "after_rst");

        // Zero-latency instance: back-to-back store then load with request held.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0040; wdata0 = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        check("l0_store_busy", {31'd0, busy0}, 32'd1);
        check("l0_store_nvalid", {31'd0, valid0}, 32'd0);
        we0 = 1'b0; wdata0 = 32'h1111_1111;
        @(negedge clk);
        check("l0_store_valid", {31'd0, valid0}, 32'd1);
        check("l0_store_mis", {31'd0, mis0}, 32'd0);
        check("l0_store_rdata", rdata0, 32'd0);
        @(negedge clk);
        check("l0_idle_busy", {31'd0, busy0}, 32'd0);
        check("l0_idle_valid", {31'd0, valid0}, 32'd0);
        @(negedge clk);
        check("l0_load_accepted", {31'd0, busy0}, 32'd1);
        check("l0_load_nvalid", {31'd0, valid0}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("l0_load_valid", {31'd0, valid0}, 32'd1);
        check("l0_load_rdata", rdata0, 32'h0BAD_F00D);
        check("l0_load_mis", {31'd0, mis0}, 32'd0);

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d completions outstanding, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
